// File: rtl/saturn_pkg.sv
// Shared encodings for the Saturn fetch sequencer: FSM states, nibble-bus commands
// and address geometry.
package saturn_pkg;

    localparam int SATURN_PC_W      = 20;
    localparam int SATURN_ADDR_NIBS = 5;

    localparam logic [2:0] LOAD_ADDR = 3'd0;
    localparam logic [2:0] FETCH     = 3'd1;
    localparam logic [2:0] DBG       = 3'd2;
    localparam logic [2:0] DECODE    = 3'd3;
    localparam logic [2:0] EXEC      = 3'd4;

    localparam logic [1:0] BUS_READ      = 2'd0;
    localparam logic [1:0] BUS_LOAD_ADDR = 2'd1;

    // Nibble idx of a PC, LSB nibble first; out-of-range indices read as zero.
    function automatic logic [3:0] pc_nibble(input logic [SATURN_PC_W-1:0] pc,
                                             input logic [2:0] idx);
        logic [3:0] nib;
        case (idx)
            3'd0:    nib = pc[3:0];
            3'd1:    nib = pc[7:4];
            3'd2:    nib = pc[11:8];
            3'd3:    nib = pc[15:12];
            3'd4:    nib = pc[19:16];
            default: nib = 4'h0;
        endcase
        return nib;
    endfunction

endpackage

// File: rtl/saturn_addr_serializer.sv
// Walks the five address nibbles of a PC, LSB first, for the LOAD_ADDR bus command.
// Advances once per acknowledged nibble and wraps to nibble 0 after the last one.
module saturn_addr_serializer
    import saturn_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic [SATURN_PC_W-1:0] i_pc,
    input  logic                   i_advance,
    output logic [3:0]             o_nibble,
    output logic                   o_last
);

    logic [2:0] nib_idx;

    assign o_last   = (nib_idx == 3'(SATURN_ADDR_NIBS - 1));
    assign o_nibble = pc_nibble(i_pc, nib_idx);

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            nib_idx <= 3'd0;
        end else if (i_advance) begin
            nib_idx <= o_last ? 3'd0 : nib_idx + 3'd1;
        end
    end

endmodule

// File: rtl/saturn_fetch_seq.sv
// Saturn instruction fetch sequencer: owns the PC, masters the nibble bus for fetch
// and strobes decode/execute. Define SATURN_FETCH_DBG_EN to insert a DBG phase.
module saturn_fetch_seq
    import saturn_pkg::*;
#(
    parameter logic [SATURN_PC_W-1:0] RESET_VECTOR = 20'h00000,
    parameter int                     PC_W         = SATURN_PC_W
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    output logic            o_bus_req,
    output logic [1:0]      o_bus_cmd,
    output logic [3:0]      o_bus_data,
    input  logic            i_bus_ack,
    input  logic [3:0]      i_bus_data,
    output logic [3:0]      o_nibble,
    output logic [PC_W-1:0] o_pc,
    output logic            o_en_dec,
    output logic            o_en_exec,
    output logic            o_en_dbg,
    output logic            o_stalled,
    input  logic            i_inc_pc,
    input  logic            i_exec_busy,
    input  logic            i_load_pc,
    input  logic [PC_W-1:0] i_new_pc,
    output logic [31:0]     o_cycles
);

    logic [2:0]      state_q, state_d;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] nib_pc_q;
    logic [3:0]      nibble_q;
    logic [31:0]     cycles_q;
    logic            reload_q;
    logic            armed_q;
    logic            in_load, bus_active, bus_done, exec_last;
    logic [3:0]      ser_nibble;
    logic            ser_last;

    // armed_q holds the bus idle for the first cycle out of reset, so a request
    // interrupted by reset is never re-presented in the cycle that follows it.
    assign in_load    = armed_q && (state_q == LOAD_ADDR);
    assign bus_active = armed_q && ((state_q == LOAD_ADDR) || (state_q == FETCH));
    assign bus_done   = bus_active && i_bus_ack;
    assign exec_last  = (state_q == EXEC) && !i_exec_busy;

    saturn_addr_serializer u_ser (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_pc      (pc_q),
        .i_advance (in_load && i_bus_ack),
        .o_nibble  (ser_nibble),
        .o_last    (ser_last)
    );

    assign o_bus_req  = bus_active;
    assign o_bus_cmd  = in_load ? BUS_LOAD_ADDR : BUS_READ;
    assign o_bus_data = in_load ? ser_nibble : 4'h0;
    assign o_nibble   = nibble_q;
    assign o_pc       = nib_pc_q;
    assign o_cycles   = cycles_q;
    assign o_en_dec   = (state_q == DECODE);
    assign o_en_exec  = (state_q == EXEC);
    assign o_stalled  = (state_q == EXEC) && i_exec_busy;
`ifdef SATURN_FETCH_DBG_EN
    assign o_en_dbg   = (state_q == DBG);
`else
    assign o_en_dbg   = 1'b0;
`endif

    // NOTE: state_d is defaulted before the case so every path assigns it and no
    // latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD_ADDR: if (bus_done && ser_last) state_d = FETCH;
`ifdef SATURN_FETCH_DBG_EN
            FETCH:     if (bus_done) state_d = DBG;
            DBG:       state_d = DECODE;
`else
            FETCH:     if (bus_done) state_d = DECODE;
`endif
            DECODE:    state_d = EXEC;
            EXEC: begin
                if (!i_exec_busy) state_d = (i_load_pc || reload_q) ? LOAD_ADDR : FETCH;
            end
            default:   state_d = LOAD_ADDR;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q  <= LOAD_ADDR;
            pc_q     <= RESET_VECTOR;
            nib_pc_q <= RESET_VECTOR;
            nibble_q <= 4'h0;
            cycles_q <= 32'd0;
            reload_q <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            armed_q  <= 1'b1;
            cycles_q <= cycles_q + 32'd1;
            if ((state_q == FETCH) && bus_done) begin
                nibble_q <= i_bus_data;
                nib_pc_q <= pc_q;
            end
            // A nibble left unconsumed leaves the auto-incremented bus pointer
            // one ahead of pc, so the address must be reloaded before refetching.
            if (state_q == DECODE) begin
                if (i_inc_pc) pc_q <= pc_q + PC_W'(1);
                else          reload_q <= 1'b1;
            end
            if (exec_last) begin
                reload_q <= 1'b0;
                if (i_load_pc) pc_q <= i_new_pc;
            end
        end
    end

`ifdef SATURN_FETCH_DBG_EN
`ifdef SIM
    always_ff @(posedge i_clk) begin
        if (i_reset_n && (state_q == DBG)) $display("%05h %1h", nib_pc_q, nibble_q);
    end
`endif
`endif

endmodule

// File: tb/tb_saturn_fetch_seq.sv
// Directed bench for saturn_fetch_seq: reset, straight-line fetch, jump, execute
// stall, PC wrap, reload after an unconsumed nibble, and reset during a pending request.
module tb_saturn_fetch_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        bus_req;
    logic [1:0]  bus_cmd;
    logic [3:0]  bus_wdata;
    logic        bus_ack = 1'b0;
    logic [3:0]  bus_rdata = 4'h0;
    logic [3:0]  nibble;
    logic [19:0] pc;
    logic        en_dec, en_exec, en_dbg, stalled;
    logic        inc_pc = 1'b0;
    logic        exec_busy = 1'b0;
    logic        load_pc = 1'b0;
    logic [19:0] new_pc = 20'h0;
    logic [31:0] cycles;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_dec = 32'd0;

    always #5 clk = ~clk;

    saturn_fetch_seq #(.RESET_VECTOR(20'h00000)) dut (
        .i_clk       (clk),
        .i_reset_n   (reset_n),
        .o_bus_req   (bus_req),
        .o_bus_cmd   (bus_cmd),
        .o_bus_data  (bus_wdata),
        .i_bus_ack   (bus_ack),
        .i_bus_data  (bus_rdata),
        .o_nibble    (nibble),
        .o_pc        (pc),
        .o_en_dec    (en_dec),
        .o_en_exec   (en_exec),
        .o_en_dbg    (en_dbg),
        .o_stalled   (stalled),
        .i_inc_pc    (inc_pc),
        .i_exec_busy (exec_busy),
        .i_load_pc   (load_pc),
        .i_new_pc    (new_pc),
        .o_cycles    (cycles)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expects LOAD_ADDR on entry; checks the five address nibbles, LSB first.
    task automatic load_addr(input logic [19:0] addr);
        for (int i = 0; i < 5; i++) begin
            check("load_req", 32'(bus_req), 32'd1);
            check("load_cmd", 32'(bus_cmd), 32'd1);
            check("load_nib", 32'(bus_wdata), 32'(addr[i*4 +: 4]));
            tick();
        end
        check("load_to_fetch_cmd", 32'(bus_cmd), 32'd0);
    endtask

    // Expects FETCH on entry; runs FETCH, DECODE and EXEC (with optional busy
    // cycles) and checks the bus command presented afterwards.
    task automatic run_nibble(input logic [3:0] nib, input logic [19:0] exp_pc,
                              input logic inc, input int busy, input logic load,
                              input logic [19:0] target, input logic [1:0] next_cmd,
                              input int spacing);
        check("fetch_req", 32'(bus_req), 32'd1);
        check("fetch_cmd", 32'(bus_cmd), 32'd0);
        bus_rdata = nib;
        inc_pc    = inc;
        tick();
        check("dec_en", 32'(en_dec), 32'd1);
        check("dec_nibble", 32'(nibble), 32'(nib));
        check("dec_pc", 32'(pc), 32'(exp_pc));
        check("dec_no_req", 32'(bus_req), 32'd0);
        check("dec_strobe_excl", 32'({en_exec, en_dbg}), 32'd0);
        if (spacing != 0) check("dec_spacing", cycles - last_dec, 32'(spacing));
        last_dec = cycles;
        tick();
        for (int k = 0; k < busy; k++) begin
            exec_busy = 1'b1;
            load_pc   = 1'b1;
            new_pc    = 20'h12345;
            #1;
            check("busy_stalled", 32'(stalled), 32'd1);
            check("busy_en_exec", 32'(en_exec), 32'd1);
            check("busy_no_req", 32'(bus_req), 32'd0);
            tick();
        end
        exec_busy = 1'b0;
        load_pc   = load;
        new_pc    = target;
        #1;
        check("exec_last_stalled", 32'(stalled), 32'd0);
        check("exec_last_en", 32'(en_exec), 32'd1);
        check("exec_no_req", 32'(bus_req), 32'd0);
        tick();
        load_pc = 1'b0;
        check("next_req", 32'(bus_req), 32'd1);
        check("next_cmd", 32'(bus_cmd), 32'(next_cmd));
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_req", 32'(bus_req), 32'd0);
        check("rst_cmd", 32'(bus_cmd), 32'd0);
        check("rst_data", 32'(bus_wdata), 32'd0);
        check("rst_nibble", 32'(nibble), 32'd0);
        check("rst_cycles", cycles, 32'd0);
        check("rst_stalled", 32'(stalled), 32'd0);
        check("rst_strobes", 32'({en_dec, en_exec, en_dbg}), 32'd0);

        // Release with a zero-wait bus; the first cycle out of reset is idle
        reset_n = 1'b1;
        bus_ack = 1'b1;
        tick();
        check("armed_cycles", cycles, 32'd1);
        load_addr(20'h00000);
        run_nibble(4'h1, 20'h00000, 1'b1, 0, 1'b0, 20'h0, 2'd0, 0);

        // Straight line, 3 cycles per nibble; the last one takes a jump
        run_nibble(4'h0, 20'h00001, 1'b1, 0, 1'b0, 20'h0, 2'd0, 3);
        run_nibble(4'h1, 20'h00002, 1'b1, 0, 1'b0, 20'h0, 2'd0, 3);
        run_nibble(4'h2, 20'h00003, 1'b1, 0, 1'b1, 20'hABCDE, 2'd1, 3);
        load_addr(20'hABCDE);
        run_nibble(4'h7, 20'hABCDE, 1'b1, 0, 1'b0, 20'h0, 2'd0, 8);

        // Execute busy for 4 cycles with a load_pc pulse that must be ignored
        run_nibble(4'h3, 20'hABCDF, 1'b1, 4, 1'b0, 20'h0, 2'd0, 3);
        run_nibble(4'h8, 20'hABCE0, 1'b1, 0, 1'b1, 20'hFFFFF, 2'd1, 7);
        load_addr(20'hFFFFF);

        // Wrap FFFFF -> 00000, then an unconsumed nibble forces a reload of 00000
        run_nibble(4'h5, 20'hFFFFF, 1'b1, 0, 1'b0, 20'h0, 2'd0, 8);
        run_nibble(4'h6, 20'h00000, 1'b0, 0, 1'b0, 20'h0, 2'd1, 3);
        load_addr(20'h00000);

        // Jump together with a pending reload: jump target wins, reload is dropped
        run_nibble(4'h6, 20'h00000, 1'b0, 0, 1'b1, 20'h54321, 2'd1, 8);
        load_addr(20'h54321);
        run_nibble(4'h9, 20'h54321, 1'b1, 0, 1'b0, 20'h0, 2'd0, 8);

        // Wait states: request holds stable, then reset lands while ack is pending
        bus_ack = 1'b0;
        tick();
        tick();
        check("wait_req", 32'(bus_req), 32'd1);
        check("wait_cmd", 32'(bus_cmd), 32'd0);
        check("wait_no_dec", 32'(en_dec), 32'd0);
        reset_n = 1'b0;
        tick();
        check("midrst_req", 32'(bus_req), 32'd0);
        check("midrst_cycles", cycles, 32'd0);
        check("midrst_nibble", 32'(nibble), 32'd0);
        reset_n = 1'b1;
        bus_ack = 1'b1;
        tick();
        load_addr(20'h00000);
        run_nibble(4'h4, 20'h00000, 1'b1, 0, 1'b0, 20'h0, 2'd0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
